// File: rtl/mc_ctrl_fsm_if.sv
// Control/handshake bundle between the multi-cycle control FSM and the datapath/memory side.
// The master modport is the controller; the slave modport is the datapath that obeys it.
interface mc_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             mem_dsel;
  logic             ir_wr;
  logic             pc_wr;
  logic             pc_sel;
  logic             jump;
  logic             jr_sel;
  logic             reg_wr;
  logic [1:0]       dst_sel;
  logic [1:0]       wd_sel;
  logic             alu_src;
  logic             ext_sel;
  logic [2:0]       alu_op;
  logic             fault;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ack,
    output mem_req, mem_we, mem_dsel, ir_wr, pc_wr, pc_sel, jump, jr_sel,
           reg_wr, dst_sel, wd_sel, alu_src, ext_sel, alu_op, fault, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ack,
    input  mem_req, mem_we, mem_dsel, ir_wr, pc_wr, pc_sel, jump, jr_sel,
           reg_wr, dst_sel, wd_sel, alu_src, ext_sel, alu_op, fault, retired
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control unit for the MIPS-subset core: fetch/decode/execute/memory/writeback
// sequencing, retired-instruction counter and sticky unsupported-opcode fault.
module mc_ctrl_fsm #(
  parameter int CNT_W  = 32,
  parameter int RA_REG = 31
) (
  input logic          Clk,
  input logic          PcReSet,
  mc_ctrl_fsm_if.master bus
);
  localparam logic [5:0] OpR = 6'h00, OpOri = 6'h0D, OpLui = 6'h0F, OpLw = 6'h23;
  localparam logic [5:0] OpSw = 6'h2B, OpBeq = 6'h04, OpJ = 6'h02, OpJal = 6'h03;
  localparam logic [5:0] FnAddu = 6'h21, FnSubu = 6'h23, FnSlt = 6'h2A, FnJr = 6'h08;
  localparam logic [2:0] AluAdd = 3'd0, AluSub = 3'd1, AluOr = 3'd2, AluSlt = 3'd3, AluLui = 3'd4;

  if (RA_REG < 0 || RA_REG > 31) begin : gBadRaReg
    $error("mc_ctrl_fsm: RA_REG must be a register index 0..31");
  end

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR, MEM_RD,
    WB_MEM, MEM_WR, BRANCH, JUMP, JR, TRAP
  } state_t;

  state_t           state, nextState;
  logic             memReqQ, memWeQ, memDselQ, pcWrQ, branchQ, jumpQ, jrSelQ, regWrQ;
  logic             aluSrcQ, extSelQ, faultQ;
  logic [1:0]       dstSelQ, wdSelQ;
  logic [2:0]       aluOpQ;
  logic [CNT_W-1:0] retiredQ;
  logic             memReq, pcWr, rArith;

  assign rArith = (bus.funct == FnAddu) || (bus.funct == FnSubu) || (bus.funct == FnSlt);

  always_comb begin
    nextState = state;
    case (state)
      FETCH:   if (bus.mem_ack) nextState = DECODE;
      DECODE: begin
        case (bus.opcode)
          OpR:         nextState = rArith ? EXEC_R : ((bus.funct == FnJr) ? JR : TRAP);
          OpOri, OpLui: nextState = EXEC_I;
          OpLw, OpSw:  nextState = ADDR;
          OpBeq:       nextState = BRANCH;
          OpJ, OpJal:  nextState = JUMP;
          default:     nextState = TRAP;
        endcase
      end
      EXEC_R:  nextState = WB_R;
      EXEC_I:  nextState = WB_I;
      ADDR:    nextState = (bus.opcode == OpLw) ? MEM_RD : MEM_WR;
      MEM_RD:  if (bus.mem_ack) nextState = WB_MEM;
      MEM_WR:  if (bus.mem_ack) nextState = FETCH;
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, JR: nextState = FETCH;
      TRAP:    nextState = TRAP;
      default: nextState = FETCH;
    endcase
  end

  // Outputs are registered from the state being entered, so each register mirrors the
  // Moore decode of the current state; memReqQ resets high because reset lands in FETCH.
  always_ff @(posedge Clk or posedge PcReSet) begin
    if (PcReSet) begin
      state    <= FETCH;
      memReqQ  <= 1'b1;
      memWeQ   <= 1'b0;
      memDselQ <= 1'b0;
      pcWrQ    <= 1'b0;
      branchQ  <= 1'b0;
      jumpQ    <= 1'b0;
      jrSelQ   <= 1'b0;
      regWrQ   <= 1'b0;
      dstSelQ  <= 2'd0;
      wdSelQ   <= 2'd0;
      aluSrcQ  <= 1'b0;
      extSelQ  <= 1'b0;
      aluOpQ   <= AluAdd;
      faultQ   <= 1'b0;
      retiredQ <= '0;
    end else begin
      state    <= nextState;
      retiredQ <= retiredQ + CNT_W'(pcWr);
      if (nextState == TRAP) faultQ <= 1'b1;
      memReqQ  <= 1'b0;
      memWeQ   <= 1'b0;
      memDselQ <= 1'b0;
      pcWrQ    <= 1'b0;
      branchQ  <= 1'b0;
      jumpQ    <= 1'b0;
      jrSelQ   <= 1'b0;
      regWrQ   <= 1'b0;
      dstSelQ  <= 2'd0;
      wdSelQ   <= 2'd0;
      aluSrcQ  <= 1'b0;
      extSelQ  <= 1'b0;
      aluOpQ   <= AluAdd;
      case (nextState)
        FETCH:  memReqQ <= 1'b1;
        EXEC_R: aluOpQ  <= (bus.funct == FnSubu) ? AluSub :
                           ((bus.funct == FnSlt) ? AluSlt : AluAdd);
        WB_R: begin
          regWrQ  <= 1'b1;
          dstSelQ <= 2'd1;
          pcWrQ   <= 1'b1;
        end
        EXEC_I: begin
          aluSrcQ <= 1'b1;
          aluOpQ  <= (bus.opcode == OpLui) ? AluLui : AluOr;
        end
        WB_I: begin
          regWrQ <= 1'b1;
          pcWrQ  <= 1'b1;
        end
        ADDR: begin
          aluSrcQ <= 1'b1;
          extSelQ <= 1'b1;
        end
        MEM_RD: begin
          memReqQ  <= 1'b1;
          memDselQ <= 1'b1;
        end
        WB_MEM: begin
          regWrQ <= 1'b1;
          wdSelQ <= 2'd1;
          pcWrQ  <= 1'b1;
        end
        MEM_WR: begin
          memReqQ  <= 1'b1;
          memDselQ <= 1'b1;
          memWeQ   <= 1'b1;
        end
        BRANCH: begin
          aluOpQ  <= AluSub;
          pcWrQ   <= 1'b1;
          branchQ <= 1'b1;
        end
        JUMP: begin
          pcWrQ <= 1'b1;
          jumpQ <= 1'b1;
          if (bus.opcode == OpJal) begin
            regWrQ  <= 1'b1;
            dstSelQ <= 2'd2;
            wdSelQ  <= 2'd2;
          end
        end
        JR: begin
          pcWrQ  <= 1'b1;
          jrSelQ <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Reset must drop an outstanding request at once; ack-qualified strobes ride on the request.
  assign memReq       = memReqQ & ~PcReSet;
  assign pcWr         = pcWrQ | (memReq & memWeQ & bus.mem_ack);
  assign bus.mem_req  = memReq;
  assign bus.mem_we   = memWeQ;
  assign bus.mem_dsel = memDselQ;
  assign bus.ir_wr    = memReq & ~memDselQ & bus.mem_ack;
  assign bus.pc_wr    = pcWr;
  assign bus.pc_sel   = branchQ & bus.zero;
  assign bus.jump     = jumpQ;
  assign bus.jr_sel   = jrSelQ;
  assign bus.reg_wr   = regWrQ;
  assign bus.dst_sel  = dstSelQ;
  assign bus.wd_sel   = wdSelQ;
  assign bus.alu_src  = aluSrcQ;
  assign bus.ext_sel  = extSelQ;
  assign bus.alu_op   = aluOpQ;
  assign bus.fault    = faultQ;
  assign bus.retired  = retiredQ;
endmodule
